// File: rtl/scope_meas_pkg.sv
// rtl/scope_meas_pkg.sv - shared FSM encoding and width/limit helpers for the scope measurement engine
package scope_meas_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  function automatic int pp_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int cmp_w(input int dw);
    return dw + 2;
  endfunction

  function automatic logic signed [31:0] smax(input int dw);
    return (32'sd1 <<< (dw - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] smin(input int dw);
    return -(32'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/scope_meas_ch.sv
// rtl/scope_meas_ch.sv - one channel: hysteresis comparator, extremes, edge count/timestamps, result registers
module scope_meas_ch
  import scope_meas_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int EDGE_W = 16,
  parameter int SPAN_W = 10,
  parameter int HYST   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     win_end,
  input  logic                     clear,
  input  logic                     strobe,
  input  logic [SPAN_W-1:0]        wcnt,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] thr,
  output logic signed [DATA_W-1:0] mid,
  output logic [EDGE_W-1:0]        edges,
  output logic [SPAN_W-1:0]        span,
  output logic signed [DATA_W-1:0] res_max,
  output logic signed [DATA_W-1:0] res_min,
  output logic [DATA_W:0]          pp
);

  localparam int CW = cmp_w(DATA_W);
  localparam int PW = pp_w(DATA_W);
  localparam logic signed [DATA_W-1:0] D_MAX = DATA_W'(smax(DATA_W));
  localparam logic signed [DATA_W-1:0] D_MIN = DATA_W'(smin(DATA_W));

  logic                     cmp_st, st_nx, edge_hit, seen, seen_nx;
  logic [EDGE_W-1:0]        cnt, cnt_nx;
  logic [SPAN_W-1:0]        first_ts, first_nx, last_ts, last_nx, span_nx;
  logic signed [DATA_W-1:0] acc_max, acc_min, max_nx, min_nx, fin_max, fin_min;
  logic signed [CW-1:0]     s_x, hi, lo;
  logic signed [PW-1:0]     sum, diff;

  always_comb begin
    s_x      = CW'(sample);
    hi       = CW'(thr) + CW'(HYST);
    lo       = CW'(thr) - CW'(HYST);
    st_nx    = cmp_st;
    edge_hit = 1'b0;
    cnt_nx   = cnt;
    first_nx = first_ts;
    last_nx  = last_ts;
    max_nx   = acc_max;
    min_nx   = acc_min;
    seen_nx  = seen;
    if (strobe) begin
      if (!cmp_st && s_x >= hi) begin
        st_nx    = 1'b1;
        edge_hit = 1'b1;
      end else if (cmp_st && s_x <= lo) begin
        st_nx = 1'b0;
      end
      if (sample > acc_max) max_nx = sample;
      if (sample < acc_min) min_nx = sample;
      seen_nx = 1'b1;
      if (edge_hit) begin
        if (cnt != '1) cnt_nx = cnt + EDGE_W'(1);
        if (cnt == '0) first_nx = wcnt;
        last_nx = wcnt;
      end
    end
    // Final values include this cycle's sample so the window-end strobe is counted.
    fin_max = seen_nx ? max_nx : '0;
    fin_min = seen_nx ? min_nx : '0;
    sum     = PW'(fin_max) + PW'(fin_min);
    diff    = PW'(fin_max) - PW'(fin_min);
    mid     = DATA_W'(sum >>> 1);
    span_nx = (cnt_nx >= EDGE_W'(2)) ? (last_nx - first_nx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_st   <= 1'b0;
      cnt      <= '0;
      first_ts <= '0;
      last_ts  <= '0;
      acc_max  <= D_MIN;
      acc_min  <= D_MAX;
      seen     <= 1'b0;
      edges    <= '0;
      span     <= '0;
      res_max  <= '0;
      res_min  <= '0;
      pp       <= '0;
    end else if (clear) begin
      cmp_st   <= 1'b0;
      cnt      <= '0;
      first_ts <= '0;
      last_ts  <= '0;
      acc_max  <= D_MIN;
      acc_min  <= D_MAX;
      seen     <= 1'b0;
    end else begin
      cmp_st <= st_nx;
      if (win_end) begin
        edges    <= cnt_nx;
        span     <= span_nx;
        res_max  <= fin_max;
        res_min  <= fin_min;
        pp       <= diff;
        cnt      <= '0;
        first_ts <= '0;
        last_ts  <= '0;
        acc_max  <= D_MIN;
        acc_min  <= D_MAX;
        seen     <= 1'b0;
      end else begin
        cnt      <= cnt_nx;
        first_ts <= first_nx;
        last_ts  <= last_nx;
        acc_max  <= max_nx;
        acc_min  <= min_nx;
        seen     <= seen_nx;
      end
    end
  end

endmodule

// File: rtl/scope_measure_mc.sv
// rtl/scope_measure_mc.sv - multi-channel scope measurement top: window FSM, window counter, thresholds, result strobe
module scope_measure_mc
  import scope_meas_pkg::*;
#(
  parameter int CH_NUM      = 2,
  parameter int DATA_W      = 12,
  parameter int GATE_CYCLES = 1_000_000,
  parameter int HYST        = 16,
  parameter int EDGE_W      = 16,
  parameter int SPAN_W      = $clog2(GATE_CYCLES)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_enable,
  input  logic                              i_adc_vld,
  input  logic [CH_NUM*DATA_W-1:0]          i_adc_data,
  input  logic                              i_auto_lvl,
  input  logic signed [DATA_W-1:0]          i_level,
  output logic [CH_NUM*EDGE_W-1:0]          o_edges,
  output logic [CH_NUM*SPAN_W-1:0]          o_span,
  output logic [CH_NUM*DATA_W-1:0]          o_max,
  output logic [CH_NUM*DATA_W-1:0]          o_min,
  output logic [CH_NUM*pp_w(DATA_W)-1:0]    o_pp,
  output logic                              o_vld,
  output logic                              o_busy
);

  localparam int PW = pp_w(DATA_W);

  fsm_t                     state;
  logic [SPAN_W-1:0]        wcnt;
  logic                     run, abort, win_end, strobe;
  logic signed [DATA_W-1:0] thr [CH_NUM];
  logic signed [DATA_W-1:0] mid [CH_NUM];

  assign run     = (state == RUN) && i_enable;
  assign abort   = (state == RUN) && !i_enable;
  assign win_end = run && (wcnt == SPAN_W'(GATE_CYCLES - 1));
  assign strobe  = run && i_adc_vld;

  // Thresholds are loaded only on window-start edges, so they hold for a whole window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      wcnt   <= '0;
      o_vld  <= 1'b0;
      o_busy <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) thr[k] <= '0;
    end else begin
      o_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable) begin
            state  <= RUN;
            o_busy <= 1'b1;
            wcnt   <= '0;
            for (int k = 0; k < CH_NUM; k++) thr[k] <= i_auto_lvl ? '0 : i_level;
          end
        end
        RUN: begin
          if (!i_enable) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            wcnt   <= '0;
          end else if (win_end) begin
            wcnt  <= '0;
            o_vld <= 1'b1;
            for (int k = 0; k < CH_NUM; k++) thr[k] <= i_auto_lvl ? mid[k] : i_level;
          end else begin
            wcnt <= wcnt + SPAN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    scope_meas_ch #(
      .DATA_W (DATA_W),
      .EDGE_W (EDGE_W),
      .SPAN_W (SPAN_W),
      .HYST   (HYST)
    ) u_ch (
      .clk     (i_clk),
      .rst     (i_rst),
      .win_end (win_end),
      .clear   (abort),
      .strobe  (strobe),
      .wcnt    (wcnt),
      .sample  (i_adc_data[k*DATA_W +: DATA_W]),
      .thr     (thr[k]),
      .mid     (mid[k]),
      .edges   (o_edges[k*EDGE_W +: EDGE_W]),
      .span    (o_span[k*SPAN_W +: SPAN_W]),
      .res_max (o_max[k*DATA_W +: DATA_W]),
      .res_min (o_min[k*DATA_W +: DATA_W]),
      .pp      (o_pp[k*PW +: PW])
    );
  end

endmodule

// File: tb/tb_scope_measure_mc.sv
// tb/tb_scope_measure_mc.sv - directed scoreboard bench for scope_measure_mc
module tb_scope_measure_mc;

  localparam int CH = 2;
  localparam int DW = 12;
  localparam int GC = 1000;
  localparam int HY = 16;
  localparam int EW = 16;
  localparam int SW = $clog2(GC);
  localparam int PW = DW + 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   enable = 1'b0;
  logic                   adc_vld = 1'b0;
  logic [CH*DW-1:0]       adc_data = '0;
  logic                   auto_lvl = 1'b0;
  logic signed [DW-1:0]   level = '0;
  logic [CH*EW-1:0]       edges;
  logic [CH*SW-1:0]       span;
  logic [CH*DW-1:0]       vmax, vmin;
  logic [CH*PW-1:0]       pp;
  logic                   vld, busy;

  always #5 clk = ~clk;

  scope_measure_mc #(
    .CH_NUM(CH), .DATA_W(DW), .GATE_CYCLES(GC), .HYST(HY), .EDGE_W(EW), .SPAN_W(SW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_adc_vld(adc_vld),
    .i_adc_data(adc_data), .i_auto_lvl(auto_lvl), .i_level(level),
    .o_edges(edges), .o_span(span), .o_max(vmax), .o_min(vmin), .o_pp(pp),
    .o_vld(vld), .o_busy(busy)
  );

  typedef struct {
    int e0, s0, mx0, mn0, pp0;
    int e1, s1, mx1, mn1, pp1;
  } res_t;

  res_t sb[$];
  int   ncmp = 0, nerr = 0;
  int   tcnt = 0, vld_tick = -1, first_run = 0;
  int   w_b = 0, m0 = 0, m1 = 0;
  bit   run_b = 0, vld_due = 0, en_b = 0, vld_b = 0, auto_b = 0;

  function automatic res_t mk(input int e0, s0, mx0, mn0, pp0, e1, s1, mx1, mn1, pp1);
    res_t r;
    r.e0 = e0; r.s0 = s0; r.mx0 = mx0; r.mn0 = mn0; r.pp0 = pp0;
    r.e1 = e1; r.s1 = s1; r.mx1 = mx1; r.mn1 = mn1; r.pp1 = pp1;
    return r;
  endfunction

  // Waveforms as a function of the window cycle; square waves rise at wcnt%100==5.
  function automatic int samp(input int mode, input int w);
    bit hi;
    hi = ((w % 100) >= 5) && ((w % 100) < 55);
    case (mode)
      1: return hi ? 1000 : -1000;
      2: return (w % 2 == 0) ? 10 : -10;
      3: return hi ? 2000 : 0;
      4: return 2047;
      5: return -2048;
      6: return hi ? 2047 : -2048;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ch(input string tag, input int k, input int e, s, mx, mn, p);
    chk({tag, "_edges"}, int'(edges[k*EW +: EW]), e);
    chk({tag, "_span"},  int'(span[k*SW +: SW]), s);
    chk({tag, "_max"},   int'($signed(vmax[k*DW +: DW])), mx);
    chk({tag, "_min"},   int'($signed(vmin[k*DW +: DW])), mn);
    chk({tag, "_pp"},    int'(pp[k*PW +: PW]), p);
  endtask

  task automatic check_res(input string tag, input res_t r);
    chk_ch({tag, "_ch0"}, 0, r.e0, r.s0, r.mx0, r.mn0, r.pp0);
    chk_ch({tag, "_ch1"}, 1, r.e1, r.s1, r.mx1, r.mn1, r.pp1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_edges"}, int'(edges), 0);
    chk({tag, "_span"},  int'(span), 0);
    chk({tag, "_max"},   int'(vmax), 0);
    chk({tag, "_min"},   int'(vmin), 0);
    chk({tag, "_pp"},    int'(pp), 0);
    chk({tag, "_vld"},   int'(vld), 0);
    chk({tag, "_busy"},  int'(busy), 0);
  endtask

  task automatic tick();
    res_t r;
    @(negedge clk);
    tcnt++;
    chk("vld", int'(vld), int'(vld_due));
    chk("busy", int'(busy), int'(run_b));
    if (vld) begin
      vld_tick = tcnt;
      chk("sb_has_entry", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        check_res("win", r);
      end
    end
    enable   = en_b;
    adc_vld  = vld_b;
    auto_lvl = auto_b;
    adc_data[0 +: DW]  = DW'(samp(m0, w_b));
    adc_data[DW +: DW] = DW'(samp(m1, w_b));
    vld_due = run_b && en_b && (w_b == GC - 1);
    if (!run_b) begin
      if (en_b) begin run_b = 1; w_b = 0; end
    end else if (!en_b) begin
      run_b = 0; w_b = 0;
    end else begin
      w_b = (w_b == GC - 1) ? 0 : w_b + 1;
    end
  endtask

  initial begin
    res_t w4;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // W1: ch0 square +-1000, ch1 alternating +-10, fixed level 0
    vld_b = 1; m0 = 1; m1 = 2; en_b = 1;
    tick();
    sb.push_back(mk(10, 900, 1000, -1000, 2000, 0, 0, 10, -10, 20));
    repeat (GC) tick();

    // W2: no strobes at all
    vld_b = 0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (GC) tick();

    // W3: full-scale constants
    vld_b = 1; m0 = 4; m1 = 5;
    sb.push_back(mk(1, 0, 2047, 2047, 0, 0, 0, -2048, -2048, 0));
    repeat (GC) tick();

    // W4: full-scale square on ch0
    m0 = 6;
    w4 = mk(10, 900, 2047, -2048, 4095, 0, 0, -2048, -2048, 0);
    sb.push_back(w4);
    repeat (GC) tick();

    // W5: abort at wcnt=500
    m0 = 1; m1 = 2;
    repeat (500) tick();
    en_b = 0;
    repeat (20) tick();
    check_res("held", w4);

    // W6/W7: automatic threshold, 0/2000 square on both channels
    auto_b = 1; m0 = 3; m1 = 3; en_b = 1;
    tick();
    first_run = tcnt + 1;
    sb.push_back(mk(1, 0, 2000, 0, 2000, 1, 0, 2000, 0, 2000));
    repeat (GC) tick();
    sb.push_back(mk(10, 900, 2000, 0, 2000, 10, 900, 2000, 0, 2000));
    repeat (GC) tick();
    chk("reenable_latency", vld_tick - first_run, GC);

    // W8: async reset at wcnt=300
    repeat (300) tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/scope_measure_mc.md
# scope_measure_mc

Multi-channel scope measurement engine that replaces the fixed single-channel comparator, frequency, max and min chain with one parametrised block. It runs on a single clock, with N ADC channels sampled under a common strobe. Per channel and per gate window, it reports:
- rising-edge count and first-to-last edge span, for reciprocal frequency;
- max, min and peak-to-peak.

Edges come from a hysteresis comparator with a fixed or automatic (mid-level) threshold. It sits between the ADC capture front end and the display/readout logic.

## Interface
- CH_NUM, 2: number of channels (1..8)
- DATA_W, 12: signed sample width
- GATE_CYCLES, 1_000_000: window length in clocks (≥4)
- HYST, 16: comparator hysteresis, in LSB (≥0)
- EDGE_W, 16: edge-counter width, saturating
- SPAN_W, $clog2(GATE_CYCLES): span width
- i_clk in 1: the block's single clock
- i_rst in 1: asynchronous, active-high reset
- i_enable in 1: run windows continuously while high
- i_adc_vld in 1: sample strobe, common to all channels
- i_adc_data in CH_NUM*DATA_W: signed samples; channel k is bits [k*DATA_W +: DATA_W]
- i_auto_lvl in 1: 1 = automatic threshold, 0 = use i_level
- i_level in DATA_W: signed fixed threshold
- o_edges out CH_NUM*EDGE_W: rising edges in the last window
- o_span out CH_NUM*SPAN_W: clocks from first to last rising edge
- o_max / o_min out CH_NUM*DATA_W: signed extremes
- o_pp out CH_NUM*(DATA_W+1): unsigned max−min
- o_vld out 1: one-cycle pulse; new results are present
- o_busy out 1: window in progress

## Operation
- FSM states:
  - IDLE → RUN when i_enable=1.
  - RUN → IDLE when i_enable=0; the window is aborted, no o_vld is issued and result registers keep their old values.
- Window counter wcnt runs 0..GATE_CYCLES−1 in RUN, then wraps to 0 with no gap between windows.
- Per channel, on cycles where i_adc_vld=1 in RUN:
  - max/min tracking.
  - Comparator, evaluated in DATA_W+2-bit signed arithmetic so it cannot overflow:
    - state goes 0→1 when sample ≥ thr+HYST;
    - state goes 1→0 when sample ≤ thr−HYST;
    - otherwise the state holds.
  - A 0→1 transition is one rising edge:
    - the edge counter increments and saturates at all-ones;
    - first_ts is captured on the first edge of the window;
    - last_ts = wcnt on every edge.
- Comparator state persists across windows. It is cleared only by reset or by RUN→IDLE.
- Threshold:
  - thr = i_level when i_auto_lvl=0;
  - otherwise thr = (prev_max+prev_min)>>>1 from the last completed window, 0 after reset or IDLE.
  - thr is sampled only at window start and is stable within a window.
- At the end of a window (the cycle with wcnt=GATE_CYCLES−1; that cycle's sample is included), per channel:
  - o_edges = count;
  - o_span = last_ts−first_ts if count≥2, else 0;
  - o_max/o_min = extremes, or both 0 if no sample was strobed;
  - o_pp = o_max−o_min, zero-extended, range 0..2^DATA_W−1;
  - the accumulators are re-initialised: max=most negative, min=most positive, count=0, ts invalid.
- The same edge that latches the results also starts the next window.

## Timing
- Reset values:
  - all outputs are 0;
  - FSM is in IDLE;
  - thr=0 and all comparator states are 0.
- Sample-to-statistic latency: 1 clock, registered.
- First RUN cycle is wcnt=0. It is the cycle after i_enable is seen high in IDLE.
- Results:
  - registered on the clock edge that ends cycle GATE_CYCLES−1;
  - o_vld is high for exactly the following cycle;
  - outputs are held until the next o_vld.
- o_busy=1 in every RUN cycle.
- i_enable falling in the final window cycle counts as an abort: no o_vld.
- Simultaneous window end and an edge: the edge is counted in the ending window.
- Async reset mid-window: immediate return to reset values, no o_vld.

## Structure
- Package scope_meas_pkg holds:
  - FSM state encoding (IDLE, RUN);
  - width helpers (pp width = DATA_W+1, comparator width = DATA_W+2);
  - min/max signed-constant functions.
- Sub-module scope_meas_ch holds one channel: comparator, extremes, edge count and timestamps, result registers. It is generated CH_NUM times.
- The top owns:
  - the FSM;
  - wcnt;
  - thr selection, with the auto threshold kept per channel;
  - o_vld.

## Test plan
Bench parameters: CH_NUM=2, DATA_W=12, GATE_CYCLES=1000, HYST=16.

1. Fixed level 0, i_adc_vld=1 every cycle, ch0 square wave ±1000 with period 100 and first rising edge at wcnt=5. Required: edges=10, span=900, max=1000, min=−1000, pp=2000, o_vld exactly one cycle after wcnt=999.
2. Ch1 alternating +10/−10 every cycle, fixed level 0. Required: edges=0, span=0, max=10, min=−10, pp=20.
3. i_auto_lvl=1, square wave 0/2000 with period 100. Required:
   - window 1 (thr=0): edges≤1;
   - window 2 (thr=1000): edges=10, span=900.
4. Ch0 constant 2047, ch1 constant −2048. Required: pp=0 on both; then a ch0 square wave −2048/2047 gives pp=4095 with no wrap.
5. Drop i_enable at wcnt=500. Required: no o_vld and old results held; on re-enable, the next o_vld comes 1000 cycles later. Assert i_rst at wcnt=300. Required: all outputs 0 at once.
6. i_adc_vld=0 for a whole window. Required: o_vld still pulses, with max=min=pp=edges=span=0.
